// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/DM memory arbiter.
//   arb_state_t   : arbiter sequencing state (idle or owning the memory for one port)
//   owner_t       : which pipeline port the in-flight transaction belongs to
//   TIMEOUT_RDATA : read data returned to the requester when a transaction is aborted
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam int unsigned TIMEOUT_RDATA = 0;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported unified memory between the instruction-fetch
// port (IF) and the data-memory port (DM). One transaction is in flight at a
// time over a req/ack memory interface with variable latency. DM has priority,
// but after MAX_DM_STREAK consecutive DM grants with IF waiting, IF is forced.
// A watchdog aborts any transaction that sees no mem_ack for TIMEOUT_CYC cycles.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   if_req/if_addr      fetch request and address (held until if_ready)
//   if_rdata/if_ready   fetched instruction and one-cycle completion pulse
//   if_stall            if_req & ~if_ready, ORed into the hazard unit
//   dm_req/dm_we/dm_addr/dm_wdata  data request (held until dm_ready)
//   dm_rdata/dm_ready   load data and one-cycle completion pulse
//   dm_stall            dm_req & ~dm_ready
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request side
//   mem_rdata/mem_ack   memory response, data valid with the single-cycle ack
//   err                 sticky watchdog-timeout flag
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MAX_DM_STREAK = 4,
  parameter int unsigned TIMEOUT_CYC   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [DATA_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  localparam int unsigned STREAK_W = $clog2(MAX_DM_STREAK + 1);
  localparam int unsigned WDOG_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);
  localparam logic [WDOG_W-1:0]   WDOG_LAST  = WDOG_W'(TIMEOUT_CYC - 1);

  arb_state_t          state;
  logic [STREAK_W-1:0] streak;
  logic [WDOG_W-1:0]   wdog;

  logic              busy;
  owner_t            owner;
  logic              wdogExpired;
  logic              done;
  logic              grantDm;
  logic              grantIf;
  logic [DATA_W-1:0] rspData;

  // NOTE: every signal gets a default at the top of always_comb, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    busy        = 1'b0;
    owner       = OWN_IF;
    wdogExpired = 1'b0;
    done        = 1'b0;
    grantDm     = 1'b0;
    grantIf     = 1'b0;
    rspData     = DATA_W'(TIMEOUT_RDATA);

    busy  = (state == IF_BUSY) || (state == DM_BUSY);
    owner = (state == DM_BUSY) ? OWN_DM : OWN_IF;

    // Ack and timeout in the same cycle: the ack wins, so expiry needs ~mem_ack.
    wdogExpired = busy && !mem_ack && (wdog == WDOG_LAST);
    done        = busy && (mem_ack || wdogExpired);

    // DM wins unless IF has already been passed over MAX_DM_STREAK times.
    grantDm = (state == IDLE) && dm_req && (!if_req || (streak < STREAK_MAX));
    grantIf = (state == IDLE) && if_req && !grantDm;

    if (busy && mem_ack) begin
      rspData = mem_rdata;
    end
  end

  // Ready and read data are combinational so the pipeline advances on the
  // same edge that retires the memory transaction.
  assign if_ready = done && (owner == OWN_IF);
  assign dm_ready = done && (owner == OWN_DM);
  assign if_rdata = if_ready ? rspData : '0;
  assign dm_rdata = dm_ready ? rspData : '0;
  assign if_stall = if_req && !if_ready;
  assign dm_stall = dm_req && !dm_ready;

  // NOTE: the reset is asynchronous, so mem_req drops the moment reset falls,
  // even mid-transaction; the memory side tolerates the abandoned request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      streak    <= '0;
      wdog      <= '0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          wdog <= '0;
          if (grantDm) begin
            state     <= DM_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            if (!if_req) begin
              streak <= '0;
            end else if (streak != STREAK_MAX) begin
              streak <= streak + 1'b1;
            end
          end else if (grantIf) begin
            state     <= IF_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            streak    <= '0;
          end
        end

        IF_BUSY, DM_BUSY: begin
          if (done) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            wdog    <= '0;
            if (wdogExpired) begin
              err <= 1'b1;
            end
          end else begin
            wdog <= wdog + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          wdog    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (default parameters:
// DATA_W=32, MAX_DM_STREAK=4, TIMEOUT_CYC=64). Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
module tb_mem_arbiter;

  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic          if_req;
  logic [DW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          if_stall;
  logic          dm_req;
  logic          dm_we;
  logic [DW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ready;
  logic          dm_stall;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          err;

  int vecCnt  = 0;
  int missCnt = 0;

  mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .if_stall  (if_stall),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .dm_stall  (dm_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCnt++;
    if (obs !== exp) begin
      missCnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    int            earlyReady;
    int            readyIdx;
    logic [DW-1:0] toData;
    logic          expIf;

    reset     = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) neg();
    check("rst mem_req",  mem_req,  0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_we",   mem_we,   0);
    check("rst err",      err,      0);
    check("rst if_ready", if_ready, 0);
    check("rst dm_ready", dm_ready, 0);
    check("rst if_rdata", if_rdata, 0);
    reset = 1'b1;

    // ---------------- IF only, ack 2 cycles after mem_req rises ----------------
    tick();
    if_req  = 1'b1;
    if_addr = 32'h0040_0000;
    neg();
    check("if1 idle mem_req", mem_req,  0);
    check("if1 idle stall",   if_stall, 1);
    tick();                                   // grant edge
    neg();
    check("if1 mem_req",  mem_req,  1);
    check("if1 mem_addr", mem_addr, 32'h0040_0000);
    check("if1 mem_we",   mem_we,   0);
    check("if1 c0 stall", if_stall, 1);
    check("if1 c0 ready", if_ready, 0);
    tick();
    neg();
    check("if1 c1 stall", if_stall, 1);
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'h2008_0005;
    neg();
    check("if1 ready", if_ready, 1);
    check("if1 rdata", if_rdata, 32'h2008_0005);
    check("if1 stall", if_stall, 0);
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    if_req    = 1'b0;
    neg();
    check("if1 ready pulse", if_ready, 0);
    check("if1 req drop",    mem_req,  0);

    // ---------------- DM store with IF pending, immediate acks ----------------
    tick();
    if_req   = 1'b1;
    if_addr  = 32'h0040_0004;
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h1001_0000;
    dm_wdata = 32'hCAFE_F00D;
    neg();
    check("st idle dm_stall", dm_stall, 1);
    tick();                                   // DM granted
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    neg();
    check("st mem_req",   mem_req,   1);
    check("st mem_we",    mem_we,    1);
    check("st mem_addr",  mem_addr,  32'h1001_0000);
    check("st mem_wdata", mem_wdata, 32'hCAFE_F00D);
    check("st dm_ready",  dm_ready,  1);
    check("st dm_stall",  dm_stall,  0);
    check("st if_ready",  if_ready,  0);
    check("st if_stall",  if_stall,  1);
    tick();
    mem_ack = 1'b0;
    dm_req  = 1'b0;
    dm_we   = 1'b0;
    neg();
    check("st gap mem_req", mem_req, 0);
    tick();                                   // IF granted after one IDLE cycle
    mem_ack   = 1'b1;
    mem_rdata = 32'h8FA8_0000;
    neg();
    check("st-if mem_addr", mem_addr, 32'h0040_0004);
    check("st-if mem_we",   mem_we,   0);
    check("st-if ready",    if_ready, 1);
    check("st-if rdata",    if_rdata, 32'h8FA8_0000);
    tick();
    mem_ack = 1'b0;
    if_req  = 1'b0;

    // ---------------- starvation: expected order DM,DM,DM,DM,IF,DM ----------------
    if_req  = 1'b1;
    if_addr = 32'h0040_0100;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h1001_0040;
    for (int i = 0; i < 6; i++) begin
      expIf = (i == 4);
      neg();
      check($sformatf("starve%0d idle", i), mem_req, 0);
      tick();
      mem_ack   = 1'b1;
      mem_rdata = 32'h0000_1000 + 32'(i);
      neg();
      check($sformatf("starve%0d addr", i), mem_addr, expIf ? 32'h0040_0100 : 32'h1001_0040);
      check($sformatf("starve%0d if_ready", i), if_ready, expIf);
      check($sformatf("starve%0d dm_ready", i), dm_ready, !expIf);
      check($sformatf("starve%0d rdata", i), expIf ? if_rdata : dm_rdata, 32'h0000_1000 + 32'(i));
      tick();
      mem_ack = 1'b0;
    end
    if_req = 1'b0;
    dm_req = 1'b0;

    // ---------------- mem_ack while IDLE is ignored ----------------
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0055;
    neg();
    check("idle-ack if_ready", if_ready, 0);
    check("idle-ack dm_ready", dm_ready, 0);
    check("idle-ack dm_rdata", dm_rdata, 0);
    tick();
    mem_ack = 1'b0;
    neg();
    check("idle-ack mem_req", mem_req, 0);

    // ---------------- ack in the last watchdog cycle: ack wins ----------------
    tick();
    dm_req    = 1'b1;
    dm_addr   = 32'h1001_0080;
    mem_rdata = 32'hFFFF_FFFF;
    tick();                                   // grant; now in mem_req cycle 0
    earlyReady = 0;
    for (int k = 0; k < 63; k++) begin
      neg();
      if (dm_ready) earlyReady++;
      tick();
    end
    mem_ack   = 1'b1;                         // mem_req cycle 63 (wdog == 63)
    mem_rdata = 32'h0000_1234;
    neg();
    check("coll early ready", earlyReady, 0);
    check("coll mem_req",     mem_req,    1);
    check("coll dm_ready",    dm_ready,   1);
    check("coll dm_rdata",    dm_rdata,   32'h0000_1234);
    tick();
    mem_ack = 1'b0;
    dm_req  = 1'b0;
    neg();
    check("coll err", err,     0);
    check("coll idle", mem_req, 0);

    // ---------------- timeout: no ack ever ----------------
    tick();
    dm_req    = 1'b1;
    dm_addr   = 32'h1001_00C0;
    mem_rdata = 32'hFFFF_FFFF;
    tick();                                   // grant; mem_req rises here
    readyIdx = -1;
    toData   = 32'hFFFF_FFFF;
    for (int k = 0; k < 80; k++) begin
      neg();
      if (dm_ready) begin
        readyIdx = k;
        toData   = dm_rdata;
        break;
      end
      tick();
    end
    // Ready in mem_req cycle 63, consumed on the 64th edge after mem_req rose.
    check("to ready cycle", readyIdx, 63);
    check("to dm_rdata",    toData,   0);
    tick();
    dm_req    = 1'b0;
    mem_rdata = '0;
    neg();
    check("to err set",  err,      1);
    check("to mem_req",  mem_req,  0);
    check("to dm_ready", dm_ready, 0);

    // next IF request is served normally; err stays set
    tick();
    if_req  = 1'b1;
    if_addr = 32'h0040_0200;
    tick();                                   // grant
    mem_ack   = 1'b1;
    mem_rdata = 32'h2402_0001;
    neg();
    check("post-to mem_addr", mem_addr, 32'h0040_0200);
    check("post-to if_ready", if_ready, 1);
    check("post-to if_rdata", if_rdata, 32'h2402_0001);
    tick();
    mem_ack = 1'b0;
    if_req  = 1'b0;
    neg();
    check("post-to err sticky", err, 1);

    // ---------------- async reset mid-transaction ----------------
    tick();
    if_req  = 1'b1;
    if_addr = 32'h0040_0300;
    tick();                                   // IF granted
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0077;
    #1;
    check("ar pre if_ready", if_ready, 1);
    #1;
    reset = 1'b0;                             // between edges
    #1;
    check("ar mem_req",  mem_req,  0);
    check("ar if_ready", if_ready, 0);
    check("ar err",      err,      0);
    check("ar mem_addr", mem_addr, 0);
    check("ar if_rdata", if_rdata, 0);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    neg();
    reset = 1'b1;
    check("ar release mem_req", mem_req, 0);
    tick();                                   // first edge after release: fresh grant
    check("ar regrant mem_req",  mem_req,  1);
    check("ar regrant mem_addr", mem_addr, 32'h0040_0300);
    neg();
    check("ar regrant stall", if_stall, 1);
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_ABCD;
    neg();
    check("ar if_ready", if_ready, 1);
    check("ar if_rdata", if_rdata, 32'h0000_ABCD);
    tick();
    mem_ack = 1'b0;
    if_req  = 1'b0;
    neg();
    check("ar final mem_req", mem_req, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch port (IF) and data-memory port (DM).
- Sequences one transaction at a time over a request/ack memory interface with variable latency.
- Gives per-port stall outputs that the hazard unit ORs into stallF/stallD/flushE.
- DM has priority, bounded by a starvation limit, and each transaction has a watchdog timeout.

Parameters:
- DATA_W, 32, data and address width.
- MAX_DM_STREAK, 4, consecutive DM grants allowed while IF waits before IF is forced.
- TIMEOUT_CYC, 64, cycles in a busy state without mem_ack before the transaction aborts.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- if_req  in  1  fetch request, held until if_ready.
- if_addr  in  DATA_W  fetch address (pcF).
- if_rdata  out  DATA_W  fetched instruction (instrF).
- if_ready  out  1  fetch complete, one-cycle pulse.
- if_stall  out  1  = if_req & ~if_ready.
- dm_req  in  1  data request, held until dm_ready.
- dm_we  in  1  data write enable.
- dm_addr  in  DATA_W  data address (aluoutM).
- dm_wdata  in  DATA_W  store data (writedataM).
- dm_rdata  out  DATA_W  load data (readdataM).
- dm_ready  out  1  data complete, one-cycle pulse.
- dm_stall  out  1  = dm_req & ~dm_ready.
- mem_req  out  1  memory request, held until mem_ack or abort.
- mem_we  out  1  memory write enable.
- mem_addr  out  DATA_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion, single-cycle.
- err  out  1  sticky timeout flag.

Behaviour:
- States: IDLE, IF_BUSY, DM_BUSY.
- Reset (reset=0, asynchronous): state=IDLE; streak=0; wdog=0; err=0; mem_req, mem_we, mem_addr, mem_wdata = 0; if_ready, dm_ready = 0; if_rdata, dm_rdata = 0.
- IDLE grant, evaluated at the edge:
  - Only dm_req: go to DM_BUSY.
  - Only if_req: go to IF_BUSY.
  - Both, streak < MAX_DM_STREAK: go to DM_BUSY.
  - Both, streak == MAX_DM_STREAK: go to IF_BUSY.
  - Neither: stay in IDLE.
- On grant, latch address, we and wdata into mem_* registers; IF grant forces mem_we=0.
- mem_req=1 is a registered output, high in every cycle the state is BUSY, starting the cycle after the grant edge.
- Streak counter:
  - DM grant while if_req=1: streak increments, saturating at MAX_DM_STREAK.
  - DM grant while if_req=0: streak=0.
  - IF grant: streak=0.
- Completion:
  - In X_BUSY with mem_ack=1: x_ready=1 combinationally in the same cycle; x_rdata=mem_rdata passthrough (stores return mem_rdata, ignored).
  - Next edge: state=IDLE, mem_req=0, wdog=0.
  - The requester drops or changes req on that edge, so IDLE never re-issues a completed request.
- Minimum transaction: 1 grant cycle + 1 busy cycle, when ack arrives in the first mem_req cycle. Back-to-back transactions have one IDLE cycle between them.
- Watchdog:
  - wdog increments every BUSY cycle without ack.
  - When wdog == TIMEOUT_CYC-1 and mem_ack=0: x_ready pulses with x_rdata=0, err sets (sticky until reset), state goes to IDLE, mem_req drops.
  - Ack and timeout in the same cycle: ack wins; err is not set.
- mem_ack in IDLE is ignored.
- A requester dropping req mid-transaction does not abort; the ready pulse is still produced and the requester ignores it.
- x_stall is combinational; it is 0 in the ready cycle so the pipeline advances on that edge.
- Reset mid-transaction: mem_req drops immediately (async); the memory side must tolerate the abandoned request.

Decomposition:
- Shared package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, IF_BUSY, DM_BUSY}.
  - owner_t enum {OWN_IF, OWN_DM}.
  - localparam TIMEOUT_RDATA = 0.
- Single module; no sub-module warranted. The streak counter and watchdog are inline registers.

Test Plan:
- IF only: if_req=1, if_addr=0x00400000, mem_ack 2 cycles after mem_req rises with mem_rdata=0x20080005 → mem_addr=0x00400000, mem_we=0; if_ready pulses 1 cycle with if_rdata=0x20080005; if_stall=1 until that cycle.
- DM store with IF pending: both req together; dm_we=1, dm_addr=0x10010000, dm_wdata=0xCAFEF00D, immediate acks → DM granted first (mem_we=1, mem_wdata=0xCAFEF00D); IF granted after one IDLE cycle.
- Starvation: dm_req held high as 5 back-to-back requests with if_req=1, MAX_DM_STREAK=4 → grant order DM,DM,DM,DM,IF,DM; streak back to 0 after the IF grant.
- Timeout: dm_req=1, mem_ack never asserted, TIMEOUT_CYC=64 → dm_ready pulses with dm_rdata=0 exactly 64 cycles after mem_req rises; err=1 and stays 1; next if_req is served normally.
- Ack/timeout collision: mem_ack=1 in the last watchdog cycle with mem_rdata=0x1234 → ready with rdata=0x1234; err remains 0.
- Async reset mid-transaction: reset=0 while IF_BUSY, between edges → mem_req, err, ready = 0 immediately; after release with if_req=1, a fresh grant occurs on the first edge.
